// File: rtl/poly_pkg.sv
// poly_pkg: shared state type, MIDI field widths and age-width helper for the voice tracker
package poly_pkg;
    localparam int MIDI_NOTE_W = 7;
    localparam int MIDI_VEL_W  = 7;
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
    function automatic int age_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/poly_voice_slot.sv
// poly_voice_slot: one voice slot holding note, velocity, active bit and saturating age
// ports: clk, rst; load (take load_note/load_vel, age=0), clear (empty slot), age_inc; active/note/vel/age state out
module poly_voice_slot
    import poly_pkg::*;
#(
    parameter int AGE_W = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   clear,
    input  logic                   age_inc,
    input  logic [MIDI_NOTE_W-1:0] load_note,
    input  logic [MIDI_VEL_W-1:0]  load_vel,
    output logic                   active,
    output logic [MIDI_NOTE_W-1:0] note,
    output logic [MIDI_VEL_W-1:0]  vel,
    output logic [AGE_W-1:0]       age
);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            active <= 1'b0;
            note   <= '0;
            vel    <= '0;
            age    <= '0;
        end else if (load) begin
            active <= 1'b1;
            note   <= load_note;
            vel    <= load_vel;
            age    <= '0;
        end else if (age_inc && active && age != '1) begin
            age    <= age + 1'b1;
        end
    end
endmodule

// File: rtl/poly_voice_tracker.sv
// poly_voice_tracker: polyphonic note tracker with slot allocation, release and oldest-voice stealing
// ports: clk, rst; note_valid/note_ready handshake with note_on/note_num/note_vel; all_off panic; clear_flags;
//        voice_active/voice_note/voice_vel flat slot buses, active_count, irq/steal pulses, sticky overflow
module poly_voice_tracker
    import poly_pkg::*;
#(
    parameter int NUM_VOICES = 8,
    parameter int STEAL_MODE = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              note_valid,
    output logic                              note_ready,
    input  logic                              note_on,
    input  logic [MIDI_NOTE_W-1:0]            note_num,
    input  logic [MIDI_VEL_W-1:0]             note_vel,
    input  logic                              all_off,
    input  logic                              clear_flags,
    output logic [NUM_VOICES-1:0]             voice_active,
    output logic [MIDI_NOTE_W*NUM_VOICES-1:0] voice_note,
    output logic [MIDI_VEL_W*NUM_VOICES-1:0]  voice_vel,
    output logic [$clog2(NUM_VOICES+1)-1:0]   active_count,
    output logic                              irq,
    output logic                              steal,
    output logic                              overflow
);
    localparam int IW = $clog2(NUM_VOICES);
    localparam int AW = age_w(NUM_VOICES);
    localparam int CW = $clog2(NUM_VOICES + 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);
    state_t                 state;
    logic [IW-1:0]          idx, match_idx, free_idx, oldest_idx, tgt;
    logic                   match_found, free_found, oldest_found;
    logic [AW-1:0]          oldest_age;
    logic                   req_on;
    logic [MIDI_NOTE_W-1:0] req_note;
    logic [MIDI_VEL_W-1:0]  req_vel;
    logic [MIDI_NOTE_W-1:0] slot_note [NUM_VOICES];
    logic [MIDI_VEL_W-1:0]  slot_vel  [NUM_VOICES];
    logic [AW-1:0]          slot_age  [NUM_VOICES];
    logic                   in_commit, miss_full, alloc, take, drop, do_load, do_clr;

    // miss_full: no matching note and no free slot, so the request must steal or drop
    always_comb begin
        in_commit = state == COMMIT && !all_off;
        miss_full = !match_found && !free_found;
        alloc     = req_on && !match_found && free_found;
        take      = req_on && miss_full && STEAL_MODE != 0;
        drop      = req_on && miss_full && STEAL_MODE == 0;
        do_load   = in_commit && req_on && (!miss_full || take);
        do_clr    = in_commit && !req_on && match_found;
        tgt       = match_found ? match_idx : free_found ? free_idx : oldest_idx;
    end

    assign note_ready = state == IDLE && !rst;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
        poly_voice_slot #(.AGE_W(AW)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (do_load && tgt == IW'(i)),
            .clear     (all_off || (do_clr && tgt == IW'(i))),
            .age_inc   (do_load && tgt != IW'(i)),
            .load_note (req_note),
            .load_vel  (req_vel),
            .active    (voice_active[i]),
            .note      (slot_note[i]),
            .vel       (slot_vel[i]),
            .age       (slot_age[i])
        );
        assign voice_note[MIDI_NOTE_W*i +: MIDI_NOTE_W] = slot_note[i];
        assign voice_vel[MIDI_VEL_W*i +: MIDI_VEL_W]    = slot_vel[i];
    end

    // active_count tracks +1/-1 per commit so it updates on the same edge as the slots
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            match_idx    <= '0;
            free_idx     <= '0;
            oldest_idx   <= '0;
            oldest_age   <= '0;
            match_found  <= 1'b0;
            free_found   <= 1'b0;
            oldest_found <= 1'b0;
            req_on       <= 1'b0;
            req_note     <= '0;
            req_vel      <= '0;
            irq          <= 1'b0;
            steal        <= 1'b0;
            overflow     <= 1'b0;
            active_count <= '0;
        end else begin
            irq          <= all_off ? |voice_active : do_load || do_clr;
            steal        <= in_commit && take;
            overflow     <= (in_commit && drop) || (overflow && !clear_flags);
            active_count <= all_off ? '0 : active_count + CW'(in_commit && alloc) - CW'(do_clr);
            if (all_off) begin
                state <= IDLE;
            end else if (state == IDLE && note_valid) begin
                state        <= SCAN;
                idx          <= '0;
                match_found  <= 1'b0;
                free_found   <= 1'b0;
                oldest_found <= 1'b0;
                req_on       <= note_on && note_vel != '0;
                req_note     <= note_num;
                req_vel      <= note_vel;
            end else if (state == SCAN) begin
                idx <= idx + 1'b1;
                if (idx == LAST)
                    state <= COMMIT;
                if (!match_found && voice_active[idx] && slot_note[idx] == req_note) begin
                    match_found <= 1'b1;
                    match_idx   <= idx;
                end
                if (!free_found && !voice_active[idx]) begin
                    free_found <= 1'b1;
                    free_idx   <= idx;
                end
                // strict compare keeps the lowest index on equal ages
                if (voice_active[idx] && (!oldest_found || slot_age[idx] > oldest_age)) begin
                    oldest_found <= 1'b1;
                    oldest_idx   <= idx;
                    oldest_age   <= slot_age[idx];
                end
            end else if (state == COMMIT) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_poly_voice_tracker.sv
// tb_poly_voice_tracker: scoreboard bench for a stealing (dut 0) and a dropping (dut 1) 4-voice tracker
module tb_poly_voice_tracker;
    typedef struct {
        int         cyc;
        logic [3:0] act;
        logic [27:0] ns;
        logic [27:0] vs;
        logic [2:0] cnt;
        logic       stl;
    } exp_t;

    logic clk;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sbq [2][$];

    logic        valid [2], non [2], rstv [2], aoff [2], clrf [2];
    logic [6:0]  nn [2], nvl [2];
    logic        ready [2], irq [2], steal [2], ovf [2];
    logic [3:0]  act [2];
    logic [27:0] vn [2], vv [2];
    logic [2:0]  cnt [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, got, want, cyc);
        end
    endtask

    function automatic logic [27:0] pk(input int a, input int b, input int c, input int d);
        return {7'(d), 7'(c), 7'(b), 7'(a)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        exp_t e;
        poly_voice_tracker #(.NUM_VOICES(4), .STEAL_MODE(g == 0 ? 1 : 0)) u (
            .clk          (clk),
            .rst          (rstv[g]),
            .note_valid   (valid[g]),
            .note_ready   (ready[g]),
            .note_on      (non[g]),
            .note_num     (nn[g]),
            .note_vel     (nvl[g]),
            .all_off      (aoff[g]),
            .clear_flags  (clrf[g]),
            .voice_active (act[g]),
            .voice_note   (vn[g]),
            .voice_vel    (vv[g]),
            .active_count (cnt[g]),
            .irq          (irq[g]),
            .steal        (steal[g]),
            .overflow     (ovf[g])
        );
        always @(negedge clk) begin
            if (steal[g] && !irq[g]) begin
                tests++;
                fails++;
                $display("FAIL steal_without_irq dut%0d cyc=%0d", g, cyc);
            end
            if (irq[g]) begin
                if (sbq[g].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_irq dut%0d cyc=%0d", g, cyc);
                end else begin
                    e = sbq[g].pop_front();
                    chk($sformatf("irq_cycle%0d", g), cyc, e.cyc);
                    chk($sformatf("active%0d", g), 32'(act[g]), 32'(e.act));
                    chk($sformatf("notes%0d", g), 32'(vn[g]), 32'(e.ns));
                    chk($sformatf("vels%0d", g), 32'(vv[g]), 32'(e.vs));
                    chk($sformatf("count%0d", g), 32'(cnt[g]), 32'(e.cnt));
                    chk($sformatf("steal%0d", g), 32'(steal[g]), 32'(e.stl));
                end
            end
        end
    end

    task automatic accept(input int d, input bit on, input int n, input int v, output int t0);
        @(negedge clk);
        chk($sformatf("ready_before_req%0d", d), 32'(ready[d]), 32'd1);
        valid[d] = 1'b1;
        non[d]   = on;
        nn[d]    = 7'(n);
        nvl[d]   = 7'(v);
        @(posedge clk);
        #1;
        valid[d] = 1'b0;
        t0 = cyc;
    endtask

    task automatic req(input int d, input bit on, input int n, input int v, input bit ex,
                       input logic [3:0] a, input logic [27:0] ns, input logic [27:0] vs,
                       input logic [2:0] c, input bit s);
        int t0;
        exp_t x;
        accept(d, on, n, v, t0);
        x = '{t0 + 5, a, ns, vs, c, s};
        if (ex) sbq[d].push_back(x);
        repeat (6) @(posedge clk);
    endtask

    task automatic rst_pulse(input int d);
        @(negedge clk);
        rstv[d] = 1'b1;
        @(negedge clk);
        rstv[d] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        for (int d = 0; d < 2; d++) begin
            valid[d] = 0; non[d] = 0; nn[d] = 0; nvl[d] = 0;
            aoff[d] = 0; clrf[d] = 0; rstv[d] = 1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(ready[d]), 0);
            chk("rst_active", 32'(act[d]), 0);
            chk("rst_buses", 32'(vn[d] | vv[d]), 0);
            chk("rst_flags", {29'd0, irq[d], steal[d], ovf[d]}, 0);
            chk("rst_count", 32'(cnt[d]), 0);
            rstv[d] = 0;
        end
        @(negedge clk);
        chk("ready_after_rst", 32'(ready[0]), 1);

        req(0, 1, 60, 100, 1, 4'b0001, pk(60, 0, 0, 0), pk(100, 0, 0, 0), 1, 0);
        req(0, 1, 64, 90, 1, 4'b0011, pk(60, 64, 0, 0), pk(100, 90, 0, 0), 2, 0);
        req(0, 0, 60, 0, 1, 4'b0010, pk(0, 64, 0, 0), pk(0, 90, 0, 0), 1, 0);
        req(0, 1, 67, 80, 1, 4'b0011, pk(67, 64, 0, 0), pk(80, 90, 0, 0), 2, 0);
        req(0, 1, 64, 0, 1, 4'b0001, pk(67, 0, 0, 0), pk(80, 0, 0, 0), 1, 0);

        rst_pulse(0);
        req(0, 1, 60, 10, 1, 4'b0001, pk(60, 0, 0, 0), pk(10, 0, 0, 0), 1, 0);
        req(0, 1, 62, 20, 1, 4'b0011, pk(60, 62, 0, 0), pk(10, 20, 0, 0), 2, 0);
        req(0, 1, 64, 30, 1, 4'b0111, pk(60, 62, 64, 0), pk(10, 20, 30, 0), 3, 0);
        req(0, 1, 65, 40, 1, 4'b1111, pk(60, 62, 64, 65), pk(10, 20, 30, 40), 4, 0);
        req(0, 1, 67, 50, 1, 4'b1111, pk(67, 62, 64, 65), pk(50, 20, 30, 40), 4, 1);
        req(0, 1, 69, 60, 1, 4'b1111, pk(67, 69, 64, 65), pk(50, 60, 30, 40), 4, 1);

        rst_pulse(0);
        req(0, 1, 62, 20, 1, 4'b0001, pk(62, 0, 0, 0), pk(20, 0, 0, 0), 1, 0);
        req(0, 1, 60, 50, 1, 4'b0011, pk(62, 60, 0, 0), pk(20, 50, 0, 0), 2, 0);
        req(0, 1, 60, 110, 1, 4'b0011, pk(62, 60, 0, 0), pk(20, 110, 0, 0), 2, 0);
        req(0, 0, 72, 0, 0, 4'b0, 28'd0, 28'd0, 0, 0);
        chk("off72_notes", 32'(vn[0]), 32'(pk(62, 60, 0, 0)));
        chk("off72_count", 32'(cnt[0]), 2);
        req(0, 1, 64, 70, 1, 4'b0111, pk(62, 60, 64, 0), pk(20, 110, 70, 0), 3, 0);

        accept(0, 1, 65, 33, t0);
        @(negedge clk);
        @(negedge clk);
        aoff[0] = 1'b1;
        @(posedge clk);
        #1;
        aoff[0] = 1'b0;
        sbq[0].push_back('{cyc, 4'b0, 28'd0, 28'd0, 3'd0, 1'b0});
        @(negedge clk);
        chk("ready_after_alloff", 32'(ready[0]), 1);
        repeat (8) @(negedge clk);
        chk("alloff_notes", 32'(vn[0]), 0);
        chk("alloff_active", 32'(act[0]), 0);

        req(0, 1, 60, 1, 1, 4'b0001, pk(60, 0, 0, 0), pk(1, 0, 0, 0), 1, 0);
        req(0, 1, 62, 2, 1, 4'b0011, pk(60, 62, 0, 0), pk(1, 2, 0, 0), 2, 0);
        req(0, 1, 64, 3, 1, 4'b0111, pk(60, 62, 64, 0), pk(1, 2, 3, 0), 3, 0);
        accept(0, 1, 65, 4, t0);
        @(negedge clk);
        @(negedge clk);
        rstv[0] = 1'b1;
        @(negedge clk);
        chk("midrst_active", 32'(act[0]), 0);
        chk("midrst_buses", 32'(vn[0] | vv[0]), 0);
        chk("midrst_misc", {26'd0, cnt[0], irq[0], steal[0], ovf[0]}, 0);
        chk("midrst_ready", 32'(ready[0]), 0);
        rstv[0] = 1'b0;
        @(negedge clk);
        chk("ready_after_midrst", 32'(ready[0]), 1);
        repeat (8) @(negedge clk);
        chk("midrst_notes_later", 32'(vn[0]), 0);

        req(1, 1, 60, 10, 1, 4'b0001, pk(60, 0, 0, 0), pk(10, 0, 0, 0), 1, 0);
        req(1, 1, 62, 20, 1, 4'b0011, pk(60, 62, 0, 0), pk(10, 20, 0, 0), 2, 0);
        req(1, 1, 64, 30, 1, 4'b0111, pk(60, 62, 64, 0), pk(10, 20, 30, 0), 3, 0);
        req(1, 1, 65, 40, 1, 4'b1111, pk(60, 62, 64, 65), pk(10, 20, 30, 40), 4, 0);
        req(1, 1, 67, 50, 0, 4'b0, 28'd0, 28'd0, 0, 0);
        chk("drop_notes", 32'(vn[1]), 32'(pk(60, 62, 64, 65)));
        chk("drop_vels", 32'(vv[1]), 32'(pk(10, 20, 30, 40)));
        chk("drop_count", 32'(cnt[1]), 4);
        chk("drop_overflow", 32'(ovf[1]), 1);
        repeat (3) @(negedge clk);
        chk("overflow_sticky", 32'(ovf[1]), 1);
        clrf[1] = 1'b1;
        @(negedge clk);
        clrf[1] = 1'b0;
        chk("overflow_cleared", 32'(ovf[1]), 0);
        accept(1, 1, 69, 5, t0);
        repeat (4) @(posedge clk);
        #1;
        clrf[1] = 1'b1;
        @(posedge clk);
        #1;
        clrf[1] = 1'b0;
        @(negedge clk);
        chk("overflow_set_wins", 32'(ovf[1]), 1);
        chk("drop2_notes", 32'(vn[1]), 32'(pk(60, 62, 64, 65)));

        repeat (4) @(negedge clk);
        chk("sb_drained0", sbq[0].size(), 0);
        chk("sb_drained1", sbq[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
